// File: rtl/spi_master.sv
// spi_master: SPI mode 0 (CPOL=0, CPHA=0), MSB-first, full-duplex initiator.
// Each accepted start sends one DATA_WIDTH-bit word on mosi and captures the
// reply from miso. Every output comes straight from a flop.
// Latency: ss is low for (1+2*DATA_WIDTH)*CLK_DIV cycles, starting the cycle
// after start is accepted. done pulses in the first GAP cycle.
// Backpressure: start is taken only while busy=0. A start seen while busy is
// dropped, not queued.
// Ports:
//   clk, rst (async, active-low)  system clock and reset
//   start, din                    transfer request and word to send
//   busy, done, dout              status, one-cycle completion pulse, received word
//   sck, ss, mosi, miso           SPI pins
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  sck,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         div_cnt, div_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;   // bits still to send after the current one
  logic [DATA_WIDTH-1:0] tx_shift, tx_nxt;
  logic [DATA_WIDTH-1:0] rx_shift, rx_nxt;
  logic [DATA_WIDTH-1:0] dout_nxt;
  logic                  sck_nxt, ss_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic                  half_end;

  assign half_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      dout     <= '0;
      sck      <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      tx_shift <= tx_nxt;
      rx_shift <= rx_nxt;
      dout     <= dout_nxt;
      sck      <= sck_nxt;
      ss       <= ss_nxt;
      mosi     <= mosi_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = half_end ? '0 : div_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    tx_nxt    = tx_shift;
    rx_nxt    = rx_shift;
    dout_nxt  = dout;
    sck_nxt   = sck;
    ss_nxt    = ss;
    mosi_nxt  = mosi;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        div_nxt = '0;
        if (start) begin
          state_nxt = SETUP;
          tx_nxt    = din;
          rx_nxt    = '0;
          bit_nxt   = BIT_LAST;
          ss_nxt    = 1'b0;
          sck_nxt   = 1'b0;
          mosi_nxt  = din[DATA_WIDTH-1];
          busy_nxt  = 1'b1;
        end
      end
      SETUP: begin
        if (half_end) begin
          // miso is sampled on the same clk edge that raises sck.
          state_nxt = HIGH;
          sck_nxt   = 1'b1;
          rx_nxt    = {rx_shift[DATA_WIDTH-2:0], miso};
        end
      end
      HIGH: begin
        if (half_end) begin
          state_nxt = LOW;
          sck_nxt   = 1'b0;
          // After the last bit, mosi holds its value through the final LOW.
          if (bit_cnt != '0) begin
            tx_nxt   = tx_shift << 1;
            mosi_nxt = tx_shift[DATA_WIDTH-2];
          end
        end
      end
      LOW: begin
        if (half_end) begin
          if (bit_cnt != '0) begin
            state_nxt = HIGH;
            bit_nxt   = bit_cnt - 1'b1;
            sck_nxt   = 1'b1;
            rx_nxt    = {rx_shift[DATA_WIDTH-2:0], miso};
          end else begin
            state_nxt = GAP;
            ss_nxt    = 1'b1;
            mosi_nxt  = 1'b0;
            dout_nxt  = rx_shift;
            done_nxt  = 1'b1;
          end
        end
      end
      GAP: begin
        if (half_end) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master.
// Covers loopback, constant miso, a behavioural mode-0 slave, an ignored
// start, a mid-frame reset, and back-to-back frames.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       busy, done, sck, ss, mosi, miso;
  logic [7:0] dout;
  logic [1:0] miso_sel;   // 0 loopback, 1 const 1, 2 const 0, 3 slave

  always #5 clk = ~clk;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .din  (din),
    .busy (busy),
    .done (done),
    .dout (dout),
    .sck  (sck),
    .ss   (ss),
    .mosi (mosi),
    .miso (miso)
  );

  // Behavioural slave: loads the response when ss falls, captures mosi on sck
  // rising, shifts on sck falling, and latches its received byte when ss rises.
  logic [7:0] sl_resp, sl_tx, sl_rx, sl_dout;
  logic       sl_p_sck = 1'b0, sl_p_ss = 1'b1;
  initial begin
    sl_tx = 8'h00; sl_rx = 8'h00; sl_dout = 8'h00;
  end
  always @(negedge clk) begin
    if (sl_p_ss && !ss) sl_tx = sl_resp;
    if (!ss && sck && !sl_p_sck) sl_rx = {sl_rx[6:0], mosi};
    if (!ss && !sck && sl_p_sck) sl_tx = sl_tx << 1;
    if (ss && !sl_p_ss) sl_dout = sl_rx;
    sl_p_sck = sck;
    sl_p_ss  = ss;
  end

  always_comb begin
    case (miso_sel)
      2'd0:    miso = mosi;
      2'd1:    miso = 1'b1;
      2'd2:    miso = 1'b0;
      default: miso = sl_tx[7];
    endcase
  end

  // Protocol monitor, sampled on the falling clock edge.
  int         cyc = 0, rise_cnt = 0, done_cnt = 0;
  int         low_len = 0, high_len = 0, ss_low_run = 0, ss_high_run = 0;
  int         last_done_cyc = 0, busy_fall_cyc = 0;
  logic [7:0] mosi_log = 8'h00;
  logic       p_sck = 1'b0, p_ss = 1'b1, p_busy = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sck && !p_sck) begin
      rise_cnt = rise_cnt + 1;
      mosi_log = {mosi_log[6:0], mosi};
    end
    if (!ss) low_len = low_len + 1;
    else begin
      if (!p_ss) ss_low_run = low_len;
      low_len = 0;
    end
    if (ss) high_len = high_len + 1;
    else begin
      if (p_ss) ss_high_run = high_len;
      high_len = 0;
    end
    if (done) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (!busy && p_busy) busy_fall_cyc = cyc;
    p_sck  = sck;
    p_ss   = ss;
    p_busy = busy;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick(1);
      if (done) seen = 1'b1;
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input logic [7:0] d);
    start = 1'b1;
    din   = d;
    tick(1);
    start = 1'b0;
  endtask

  int rise_base, done_base;
  int t0, t1, t2;

  task automatic run_frame(input logic [7:0] d, input string tag);
    rise_base = rise_cnt;
    done_base = done_cnt;
    pulse_start(d);
    wait_done(tag);
    tick(6);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    din      = 8'h00;
    miso_sel = 2'd0;
    sl_resp  = 8'h96;

    // Reset state
    tick(3);
    chk("rst_ss", {31'd0, ss}, 32'd1);
    chk("rst_sck", {31'd0, sck}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    rst = 1'b1;
    tick(2);

    // Loopback A5
    run_frame(8'hA5, "lb");
    chk("lb_dout", {24'd0, dout}, 32'hA5);
    chk("lb_mosi_bits", {24'd0, mosi_log}, 32'hA5);
    chk("lb_sck_rises", rise_cnt - rise_base, 32'd8);
    chk("lb_ss_low", ss_low_run, 32'd68);
    chk("lb_done_cnt", done_cnt - done_base, 32'd1);
    chk("lb_busy_after_done", busy_fall_cyc - last_done_cyc, 32'd4);

    // miso stuck high / stuck low
    miso_sel = 2'd1;
    run_frame(8'h00, "m1");
    chk("m1_dout", {24'd0, dout}, 32'hFF);
    chk("m1_mosi_bits", {24'd0, mosi_log}, 32'h00);
    miso_sel = 2'd2;
    run_frame(8'hFF, "m0");
    chk("m0_dout", {24'd0, dout}, 32'h00);
    chk("m0_mosi_bits", {24'd0, mosi_log}, 32'hFF);

    // Against the slave model
    miso_sel = 2'd3;
    run_frame(8'h3C, "sl");
    chk("sl_slave_rx", {24'd0, sl_dout}, 32'h3C);
    chk("sl_master_rx", {24'd0, dout}, 32'h96);

    // Start while busy is ignored
    miso_sel  = 2'd0;
    rise_base = rise_cnt;
    done_base = done_cnt;
    pulse_start(8'h69);
    tick(19);
    pulse_start(8'h11);
    wait_done("ign");
    tick(6);
    chk("ign_dout", {24'd0, dout}, 32'h69);
    chk("ign_mosi_bits", {24'd0, mosi_log}, 32'h69);
    chk("ign_sck_rises", rise_cnt - rise_base, 32'd8);
    tick(20);
    chk("ign_no_second_ss", {31'd0, ss}, 32'd1);
    chk("ign_no_second_busy", {31'd0, busy}, 32'd0);
    chk("ign_done_cnt", done_cnt - done_base, 32'd1);

    // Reset mid-frame
    done_base = done_cnt;
    pulse_start(8'hE7);
    tick(29);
    rst = 1'b0;
    #1;
    chk("ar_ss", {31'd0, ss}, 32'd1);
    chk("ar_sck", {31'd0, sck}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_dout", {24'd0, dout}, 32'd0);
    tick(3);
    rst = 1'b1;
    tick(3);
    chk("ar_no_done", done_cnt - done_base, 32'd0);
    chk("ar_dout_held", {24'd0, dout}, 32'd0);
    run_frame(8'h5A, "ar2");
    chk("ar2_dout", {24'd0, dout}, 32'h5A);

    // start held high: 68 ss-low + 5 ss-high = 73 cycles per frame
    din   = 8'hC3;
    start = 1'b1;
    wait_done("bb0");
    t0 = cyc;
    wait_done("bb1");
    t1 = cyc;
    wait_done("bb2");
    t2 = cyc;
    start = 1'b0;
    chk("bb_period01", t1 - t0, 32'd73);
    chk("bb_period12", t2 - t1, 32'd73);
    chk("bb_ss_high", ss_high_run, 32'd5);
    chk("bb_dout", {24'd0, dout}, 32'hC3);
    tick(12);
    chk("bb_stop_ss", {31'd0, ss}, 32'd1);
    chk("bb_stop_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
